reg_writeback_ctrl: RTL and testbench

Write-side controller for the 32×32 register file. It merges two result streams onto the file's single write port (`en`, `w_adr`, `w_data`):
- single-cycle results from the ALU path;
- multi-cycle results (load/divide unit) arriving over a valid/ready handshake.

A destination-register scoreboard gives decode a stall signal, so no instruction reads or overwrites a register with a multi-cycle write still pending. It sits between execute/memory and the register file's write port.

---
 rtl/reg_writeback_ctrl_if.sv | 29 ++
 rtl/reg_writeback_ctrl.sv | 55 +++++
 tb/tb_reg_writeback_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reg_writeback_ctrl_if.sv
// reg_writeback_ctrl_if: result streams, decode check and register-file write port bundle
interface reg_writeback_ctrl_if;
   logic        fast_valid;
   logic [4:0]  fast_adr;
   logic [31:0] fast_data;
   logic        issue_valid;
   logic [4:0]  issue_adr;
   logic        slow_valid;
   logic [4:0]  slow_adr;
   logic [31:0] slow_data;
   logic        slow_ready;
   logic [4:0]  chk_adr1;
   logic [4:0]  chk_adr2;
   logic [4:0]  chk_rd;
   logic        stall;
   logic        en;
   logic [4:0]  w_adr;
   logic [31:0] w_data;
   modport master (
      output fast_valid, fast_adr, fast_data, issue_valid, issue_adr,
      output slow_valid, slow_adr, slow_data, chk_adr1, chk_adr2, chk_rd,
      input  slow_ready, stall, en, w_adr, w_data
   );
   modport slave (
      input  fast_valid, fast_adr, fast_data, issue_valid, issue_adr,
      input  slow_valid, slow_adr, slow_data, chk_adr1, chk_adr2, chk_rd,
      output slow_ready, stall, en, w_adr, w_data
   );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: merges fast and buffered slow results onto the register-file write port with a busy scoreboard
module reg_writeback_ctrl #(
   parameter int DEPTH = 2
) (
   input logic                 clk,
   input logic                 rst,
   reg_writeback_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   logic [4:0]    adr_q  [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   busy_q, busy_d;
   logic          have, push, pop;
   logic [4:0]    sel_adr;
   // fast result has strict priority; otherwise the buffer head drains, x0 never written
   always_comb begin
      have           = cnt_q != '0;
      bus.slow_ready = !rst && !cnt_q[AW];
      push           = bus.slow_valid && bus.slow_ready;
      pop            = !bus.fast_valid && have;
      sel_adr        = bus.fast_valid ? bus.fast_adr : have ? adr_q[rd_q] : 5'd0;
      bus.en         = !rst && (bus.fast_valid || have) && sel_adr != 5'd0;
      bus.w_adr      = rst ? 5'd0 : sel_adr;
      bus.w_data     = rst ? 32'd0 : bus.fast_valid ? bus.fast_data : have ? data_q[rd_q] : 32'd0;
      rd_d           = pop ? rd_q + 1'b1 : rd_q;
      wr_d           = push ? wr_q + 1'b1 : wr_q;
      cnt_d          = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      busy_d         = ((busy_q & ~(pop ? 32'd1 << adr_q[rd_q] : 32'd0))
                       | (bus.issue_valid ? 32'd1 << bus.issue_adr : 32'd0)) & ~32'd1;
      bus.stall      = busy_q[bus.chk_adr1] | busy_q[bus.chk_adr2] | busy_q[bus.chk_rd];
   end
   // pointers, occupancy and scoreboard; reset discards everything pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         busy_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end
   // buffer storage; contents are only meaningful while counted
   always_ff @(posedge clk) begin
      if (push) begin
         adr_q[wr_q]  <= bus.slow_adr;
         data_q[wr_q] <= bus.slow_data;
      end
   end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed vectors with hand-computed expectations
module tb_reg_writeback_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] pend;
   reg_writeback_ctrl_if bus ();
   reg_writeback_ctrl #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   // issued-but-not-returned destinations, used to flag illegal stimulus
   always @(posedge clk or posedge rst) begin
      if (rst) pend <= '0;
      else begin
         assert (!(bus.slow_valid && bus.slow_ready && bus.slow_adr != 0 && !pend[bus.slow_adr]))
            else $error("illegal: slow result to %0d without issue", bus.slow_adr);
         assert (!(bus.issue_valid && pend[bus.issue_adr]))
            else $error("illegal: issue to pending %0d", bus.issue_adr);
         assert (!(bus.fast_valid && bus.fast_adr != 0 && pend[bus.fast_adr]))
            else $error("illegal: fast write to pending %0d", bus.fast_adr);
         if (bus.slow_valid && bus.slow_ready) pend[bus.slow_adr] <= 1'b0;
         if (bus.issue_valid) pend[bus.issue_adr] <= 1'b1;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step(input logic fv, input logic [4:0] fa, input logic [31:0] fd,
                       input logic iv, input logic [4:0] ia,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd);
      @(posedge clk);
      #1;
      bus.fast_valid = fv; bus.fast_adr = fa; bus.fast_data = fd;
      bus.issue_valid = iv; bus.issue_adr = ia;
      bus.slow_valid = sv; bus.slow_adr = sa; bus.slow_data = sd;
      #1;
   endtask
   initial begin
      bus.fast_valid = 0; bus.fast_adr = 0; bus.fast_data = 0;
      bus.issue_valid = 0; bus.issue_adr = 0;
      bus.slow_valid = 0; bus.slow_adr = 0; bus.slow_data = 0;
      bus.chk_adr1 = 0; bus.chk_adr2 = 0; bus.chk_rd = 0;
      step(1, 5, 32'h0BAD, 0, 0, 0, 0, 0);
      check("rst_en", bus.en, 0);
      check("rst_ready", bus.slow_ready, 0);
      check("rst_wadr", bus.w_adr, 0);
      check("rst_wdata", bus.w_data, 0);
      check("rst_stall", bus.stall, 0);
      bus.fast_valid = 0;
      rst = 0;
      #1;
      check("rel_ready", bus.slow_ready, 1);
      check("rel_en", bus.en, 0);
      step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      check("fast_en", bus.en, 1);
      check("fast_wadr", bus.w_adr, 5);
      check("fast_wdata", bus.w_data, 32'hDEADBEEF);
      step(1, 0, 32'hCAFE, 0, 0, 0, 0, 0);
      check("fast_x0_en", bus.en, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("idle_en", bus.en, 0);
      check("idle_wadr", bus.w_adr, 0);
      bus.chk_adr1 = 7;
      step(0, 0, 0, 1, 7, 0, 0, 0);
      check("iss_stall_same", bus.stall, 0);
      step(0, 0, 0, 0, 0, 1, 7, 32'h1234);
      check("iss_stall_next", bus.stall, 1);
      check("slow_acc_ready", bus.slow_ready, 1);
      check("slow_acc_en", bus.en, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("slow_en", bus.en, 1);
      check("slow_wadr", bus.w_adr, 7);
      check("slow_wdata", bus.w_data, 32'h1234);
      check("slow_stall_wr", bus.stall, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("slow_stall_clr", bus.stall, 0);
      check("slow_done_en", bus.en, 0);
      bus.chk_adr1 = 0;
      step(0, 0, 0, 1, 10, 0, 0, 0);
      step(0, 0, 0, 1, 11, 0, 0, 0);
      step(1, 1, 32'h11, 1, 12, 1, 10, 32'hA5A5);
      check("f1_wadr", bus.w_adr, 1);
      check("f1_ready", bus.slow_ready, 1);
      step(1, 2, 32'h22, 0, 0, 1, 11, 32'hB6B6);
      check("f2_wadr", bus.w_adr, 2);
      check("f2_ready", bus.slow_ready, 1);
      step(1, 3, 32'h33, 0, 0, 1, 12, 32'hC7C7);
      check("full_ready", bus.slow_ready, 0);
      check("f3_wadr", bus.w_adr, 3);
      check("f3_wdata", bus.w_data, 32'h33);
      step(0, 0, 0, 0, 0, 1, 12, 32'hC7C7);
      check("pop_ready", bus.slow_ready, 0);
      check("pop1_en", bus.en, 1);
      check("pop1_wadr", bus.w_adr, 10);
      check("pop1_wdata", bus.w_data, 32'hA5A5);
      bus.chk_adr2 = 12;
      step(0, 0, 0, 0, 0, 1, 12, 32'hC7C7);
      check("after_pop_ready", bus.slow_ready, 1);
      check("pop2_wadr", bus.w_adr, 11);
      check("pop2_wdata", bus.w_data, 32'hB6B6);
      check("c12_stall", bus.stall, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("pop3_en", bus.en, 1);
      check("pop3_wadr", bus.w_adr, 12);
      check("pop3_wdata", bus.w_data, 32'hC7C7);
      check("pop3_stall", bus.stall, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("drained_en", bus.en, 0);
      check("c12_stall_clr", bus.stall, 0);
      bus.chk_adr2 = 0;
      bus.chk_rd = 9;
      step(0, 0, 0, 1, 9, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 9, 32'h99);
      check("r9_stall", bus.stall, 1);
      step(0, 0, 0, 1, 9, 0, 0, 0);
      check("r9_pop_wadr", bus.w_adr, 9);
      check("r9_pop_en", bus.en, 1);
      step(0, 0, 0, 0, 0, 1, 9, 32'h98);
      check("r9_set_wins", bus.stall, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("r9_second_wdata", bus.w_data, 32'h98);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("r9_stall_clr", bus.stall, 0);
      bus.chk_rd = 0;
      step(0, 0, 0, 1, 3, 0, 0, 0);
      step(1, 1, 32'h1, 1, 4, 1, 3, 32'h33);
      step(1, 2, 32'h2, 0, 0, 1, 4, 32'h44);
      bus.chk_adr1 = 3;
      step(1, 1, 32'h5, 0, 0, 0, 0, 0);
      check("pre_rst_stall", bus.stall, 1);
      check("pre_rst_ready", bus.slow_ready, 0);
      rst = 1;
      #1;
      check("mid_rst_en", bus.en, 0);
      check("mid_rst_stall", bus.stall, 0);
      check("mid_rst_ready", bus.slow_ready, 0);
      check("mid_rst_wadr", bus.w_adr, 0);
      bus.fast_valid = 0;
      @(posedge clk);
      #1;
      rst = 0;
      #1;
      check("post_rst_ready", bus.slow_ready, 1);
      check("post_rst_en", bus.en, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("no_stale_en1", bus.en, 0);
      check("no_stale_stall", bus.stall, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("no_stale_en2", bus.en, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
